// File: rtl/snn_config_loader_if.sv
// Byte-serial configuration load port for the SNN config loader.
// The master side drives load pulses and bytes; the loader answers with ready.
`timescale 1ns/1ps

interface snn_config_loader_if;
  logic       load_start;
  logic       cfg_valid;
  logic [7:0] cfg_data;
  logic       cfg_ready;

  modport master (
    output load_start,
    output cfg_valid,
    output cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  load_start,
    input  cfg_valid,
    input  cfg_data,
    output cfg_ready
  );
endinterface

// File: rtl/snn_config_loader.sv
// Assembles the SNN's wide static configuration (weights, delays, neuron parameters)
// from a byte stream and flags when a complete image is held.
`timescale 1ns/1ps

module snn_config_loader #(
  parameter int WEIGHT_BITS = 160,
  parameter int DELAY_BITS  = 320,
  parameter int PARAM_BITS  = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  snn_config_loader_if.slave     cfg,
  output logic [WEIGHT_BITS-1:0] weights,
  output logic [DELAY_BITS-1:0]  delays,
  output logic [PARAM_BITS-1:0]  threshold,
  output logic [PARAM_BITS-1:0]  decay,
  output logic [PARAM_BITS-1:0]  refractory_period,
  output logic                   config_valid,
  output logic                   cfg_overrun,
  output logic [5:0]             byte_count
);

  localparam int WB        = WEIGHT_BITS / 8;
  localparam int DB        = DELAY_BITS / 8;
  localparam int NUM_BYTES = WB + DB + 3;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_e;

  state_e                 state_q;
  logic [WEIGHT_BITS-1:0] weights_q;
  logic [DELAY_BITS-1:0]  delays_q;
  logic [PARAM_BITS-1:0]  threshold_q;
  logic [PARAM_BITS-1:0]  decay_q;
  logic [PARAM_BITS-1:0]  refractory_q;
  logic                   config_valid_q;
  logic                   cfg_overrun_q;
  logic [5:0]             byte_count_q;

  // load_start outranks any byte offered in the same cycle; old contents are
  // deliberately kept across a restart and only replaced slot by slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      weights_q      <= '0;
      delays_q       <= '0;
      threshold_q    <= '0;
      decay_q        <= '0;
      refractory_q   <= '0;
      config_valid_q <= 1'b0;
      cfg_overrun_q  <= 1'b0;
      byte_count_q   <= '0;
    end else if (cfg.load_start) begin
      state_q        <= LOAD;
      byte_count_q   <= '0;
      config_valid_q <= 1'b0;
      cfg_overrun_q  <= 1'b0;
    end else if (cfg.cfg_valid) begin
      if (state_q == LOAD) begin
        for (int k = 0; k < WB; k++) begin
          if (byte_count_q == 6'(k)) begin
            weights_q[8*k +: 8] <= cfg.cfg_data;
          end
        end
        for (int k = 0; k < DB; k++) begin
          if (byte_count_q == 6'(WB + k)) begin
            delays_q[8*k +: 8] <= cfg.cfg_data;
          end
        end
        if (byte_count_q == 6'(WB + DB)) begin
          threshold_q <= cfg.cfg_data[PARAM_BITS-1:0];
        end
        if (byte_count_q == 6'(WB + DB + 1)) begin
          decay_q <= cfg.cfg_data[PARAM_BITS-1:0];
        end
        if (byte_count_q == 6'(WB + DB + 2)) begin
          refractory_q <= cfg.cfg_data[PARAM_BITS-1:0];
        end
        byte_count_q <= byte_count_q + 6'd1;
        if (byte_count_q == 6'(NUM_BYTES - 1)) begin
          state_q        <= DONE;
          config_valid_q <= 1'b1;
        end
      end else begin
        cfg_overrun_q <= 1'b1;
      end
    end
  end

  assign cfg.cfg_ready       = (state_q == LOAD);
  assign weights             = weights_q;
  assign delays              = delays_q;
  assign threshold           = threshold_q;
  assign decay               = decay_q;
  assign refractory_period   = refractory_q;
  assign config_valid        = config_valid_q;
  assign cfg_overrun         = cfg_overrun_q;
  assign byte_count          = byte_count_q;

endmodule

// File: tb/tb_snn_config_loader.sv
// Self-checking bench for snn_config_loader: accepted bytes go into a scoreboard
// queue and are retired into an expected image that is compared slot by slot.
`timescale 1ns/1ps

module tb_snn_config_loader;

  localparam int WEIGHT_BITS = 160;
  localparam int DELAY_BITS  = 320;
  localparam int PARAM_BITS  = 6;
  localparam int WB          = WEIGHT_BITS / 8;
  localparam int DB          = DELAY_BITS / 8;
  localparam int NUM_BYTES   = WB + DB + 3;
  localparam logic [7:0] PMASK = 8'h3F;

  typedef struct packed {
    logic [5:0] slot;
    logic [7:0] data;
  } sbEntry_t;

  logic clk = 1'b0;
  logic reset;

  logic [WEIGHT_BITS-1:0] weights;
  logic [DELAY_BITS-1:0]  delays;
  logic [PARAM_BITS-1:0]  threshold;
  logic [PARAM_BITS-1:0]  decay;
  logic [PARAM_BITS-1:0]  refractory_period;
  logic                   config_valid;
  logic                   cfg_overrun;
  logic [5:0]             byte_count;

  int tests = 0;
  int fails = 0;
  int expCount = 0;
  sbEntry_t sbQ[$];
  logic [7:0] expImg [0:NUM_BYTES-1];

  snn_config_loader_if cfgIf ();

  snn_config_loader #(
    .WEIGHT_BITS(WEIGHT_BITS),
    .DELAY_BITS (DELAY_BITS),
    .PARAM_BITS (PARAM_BITS)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cfg              (cfgIf),
    .weights          (weights),
    .delays           (delays),
    .threshold        (threshold),
    .decay            (decay),
    .refractory_period(refractory_period),
    .config_valid     (config_valid),
    .cfg_overrun      (cfg_overrun),
    .byte_count       (byte_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] getSlot(input int k);
    if (k < WB) return weights[8*k +: 8];
    else if (k < WB + DB) return delays[8*(k-WB) +: 8];
    else if (k == WB + DB) return 8'(threshold);
    else if (k == WB + DB + 1) return 8'(decay);
    else return 8'(refractory_period);
  endfunction

  task automatic clearModel();
    sbQ.delete();
    for (int k = 0; k < NUM_BYTES; k++) expImg[k] = 8'h00;
    expCount = 0;
  endtask

  // Retire every queued transfer into the expected image, then compare all slots.
  task automatic checkImage(input string tag);
    sbEntry_t e;
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      expImg[e.slot] = (int'(e.slot) >= WB + DB) ? (e.data & PMASK) : e.data;
    end
    for (int k = 0; k < NUM_BYTES; k++) begin
      tests++;
      if (getSlot(k) !== expImg[k]) begin
        fails++;
        $display("[TB] FAIL %s slot %0d: got %h expected %h", tag, k, getSlot(k), expImg[k]);
      end
    end
  endtask

  task automatic startLoad();
    cfgIf.load_start = 1'b1;
    cfgIf.cfg_valid  = 1'b0;
    @(negedge clk);
    cfgIf.load_start = 1'b0;
    expCount = 0;
    tests++;
    if (cfgIf.cfg_ready !== 1'b1 || byte_count !== 6'd0 || config_valid !== 1'b0 || cfg_overrun !== 1'b0) begin
      fails++;
      $display("[TB] FAIL start_load: ready=%b count=%0d valid=%b overrun=%b expected 1/0/0/0",
               cfgIf.cfg_ready, byte_count, config_valid, cfg_overrun);
    end
  endtask

  // Offers n bytes (index value or a constant), optionally with random idle gaps.
  task automatic sendBytes(input int n, input bit useIndex, input logic [7:0] constVal, input bit gaps);
    int sent = 0;
    int guard = 0;
    logic v;
    logic [7:0] d;
    while (sent < n && guard < 2000) begin
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      d = useIndex ? 8'(expCount) : constVal;
      cfgIf.cfg_valid = v;
      cfgIf.cfg_data  = d;
      if (v) begin
        sbQ.push_back('{slot: 6'(expCount), data: d});
        expCount++;
        sent++;
      end
      @(negedge clk);
      tests++;
      if (byte_count !== 6'(expCount) || config_valid !== (expCount == NUM_BYTES) ||
          cfgIf.cfg_ready !== (expCount != NUM_BYTES)) begin
        fails++;
        $display("[TB] FAIL transfer: count=%0d valid=%b ready=%b expected %0d/%b/%b",
                 byte_count, config_valid, cfgIf.cfg_ready, expCount,
                 expCount == NUM_BYTES, expCount != NUM_BYTES);
      end
      guard++;
    end
    cfgIf.cfg_valid = 1'b0;
    if (sent < n) begin
      tests++;
      fails++;
      $display("[TB] FAIL send_timeout: sent %0d expected %0d", sent, n);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (cfgIf.cfg_ready !== 1'b0 || config_valid !== 1'b0 || byte_count !== 6'd0 || cfg_overrun !== 1'b0 ||
        weights !== '0 || delays !== '0 || threshold !== '0 || decay !== '0 || refractory_period !== '0) begin
      fails++;
      $display("[TB] FAIL reset_state: ready=%b valid=%b count=%0d overrun=%b thr=%h expected all zero",
               cfgIf.cfg_ready, config_valid, byte_count, cfg_overrun, threshold);
    end
    cfgIf.cfg_valid = 1'b1;
    cfgIf.cfg_data  = 8'h77;
    @(negedge clk);
    cfgIf.cfg_valid = 1'b0;
    tests++;
    if (cfg_overrun !== 1'b1 || byte_count !== 6'd0 || weights !== '0) begin
      fails++;
      $display("[TB] FAIL idle_overrun: overrun=%b count=%0d w0=%h expected 1/0/00",
               cfg_overrun, byte_count, weights[7:0]);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests++;
    if (cfg_overrun !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_clears_overrun: got %b expected 0", cfg_overrun);
    end
  endtask

  task automatic test_back_to_back();
    startLoad();
    sendBytes(NUM_BYTES, 1'b1, 8'h00, 1'b0);
    checkImage("back_to_back");
    tests++;
    if (weights[7:0] !== 8'h00 || weights[159:152] !== 8'h13 || delays[7:0] !== 8'h14 ||
        delays[319:312] !== 8'h3B || threshold !== 6'h3C || decay !== 6'h3D || refractory_period !== 6'h3E) begin
      fails++;
      $display("[TB] FAIL b2b_spot: w=%h/%h d=%h/%h t=%h dc=%h r=%h expected 00/13/14/3b/3c/3d/3e",
               weights[7:0], weights[159:152], delays[7:0], delays[319:312], threshold, decay, refractory_period);
    end
  endtask

  task automatic test_random_gaps();
    startLoad();
    sendBytes(NUM_BYTES, 1'b1, 8'h00, 1'b1);
    checkImage("random_gaps");
  endtask

  task automatic test_overrun();
    cfgIf.cfg_valid = 1'b1;
    cfgIf.cfg_data  = 8'hFF;
    @(negedge clk);
    cfgIf.cfg_valid = 1'b0;
    tests++;
    if (cfg_overrun !== 1'b1 || config_valid !== 1'b1 || byte_count !== 6'(NUM_BYTES)) begin
      fails++;
      $display("[TB] FAIL done_overrun: overrun=%b valid=%b count=%0d expected 1/1/%0d",
               cfg_overrun, config_valid, byte_count, NUM_BYTES);
    end
    checkImage("overrun_unchanged");
    startLoad();
  endtask

  task automatic test_restart();
    startLoad();
    sendBytes(10, 1'b0, 8'hAA, 1'b0);
    cfgIf.load_start = 1'b1;
    cfgIf.cfg_valid  = 1'b1;
    cfgIf.cfg_data   = 8'h55;
    @(negedge clk);
    cfgIf.load_start = 1'b0;
    cfgIf.cfg_valid  = 1'b0;
    expCount = 0;
    tests++;
    if (byte_count !== 6'd0 || cfg_overrun !== 1'b0 || config_valid !== 1'b0 || cfgIf.cfg_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL restart: count=%0d overrun=%b valid=%b ready=%b expected 0/0/0/1",
               byte_count, cfg_overrun, config_valid, cfgIf.cfg_ready);
    end
    checkImage("restart_partial");
    sendBytes(NUM_BYTES, 1'b0, 8'h0F, 1'b0);
    checkImage("restart_full");
    tests++;
    if (threshold !== 6'h0F || config_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL restart_final: thr=%h valid=%b expected 0f/1", threshold, config_valid);
    end
  endtask

  task automatic test_async_reset();
    startLoad();
    sendBytes(30, 1'b1, 8'h00, 1'b0);
    cfgIf.cfg_valid = 1'b1;
    cfgIf.cfg_data  = 8'h99;
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (weights !== '0 || delays !== '0 || threshold !== '0 || decay !== '0 || refractory_period !== '0 ||
        byte_count !== 6'd0 || config_valid !== 1'b0 || cfg_overrun !== 1'b0 || cfgIf.cfg_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL async_reset: count=%0d ready=%b w0=%h d29=%h expected all zero",
               byte_count, cfgIf.cfg_ready, weights[7:0], getSlot(29));
    end
    @(negedge clk);
    cfgIf.cfg_valid = 1'b0;
    reset = 1'b0;
    clearModel();
    @(negedge clk);
    tests++;
    if (cfgIf.cfg_ready !== 1'b0 || byte_count !== 6'd0) begin
      fails++;
      $display("[TB] FAIL post_reset_idle: ready=%b count=%0d expected 0/0", cfgIf.cfg_ready, byte_count);
    end
    checkImage("post_reset");
  endtask

  initial begin
    reset = 1'b1;
    cfgIf.load_start = 1'b0;
    cfgIf.cfg_valid  = 1'b0;
    cfgIf.cfg_data   = 8'h00;
    clearModel();
    test_reset();
    test_back_to_back();
    test_random_gaps();
    test_overrun();
    test_restart();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
